ex_muldiv_ctrl: RTL

//  Sequences an iterative multiply/divide unit beside the EX stage; owns architectural HI/LO.

---
 rtl/ex_muldiv_ctrl_pkg.sv | 25 ++
 rtl/ex_muldiv_core.sv | 59 +++++
 rtl/ex_muldiv_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared encodings for the EX-side iterative multiply/divide unit.
// Op codes match the decoder's 2-bit mul/div field; states are visible on dbg_state.
package ex_muldiv_ctrl_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/ex_muldiv_core.sv
// Unsigned shift-add multiplier / restoring divider datapath, one bit per step.
// After WIDTH steps: multiply leaves the product in {hi,lo}; divide leaves remainder in hi, quotient in lo.
module ex_muldiv_core
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [WIDTH-1:0] hi_q, lo_q, b_q;
  logic             div_q;
  logic [WIDTH:0]   add_sum, shifted, diff;

  always_comb begin
    add_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    shifted = {hi_q, lo_q[WIDTH-1]};
    // Partial remainder is always below the divisor, so diff[WIDTH] is a clean borrow.
    diff    = shifted - {1'b0, b_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      div_q <= 1'b0;
    end else if (load) begin
      hi_q  <= '0;
      lo_q  <= a;
      b_q   <= b;
      div_q <= mode_div;
    end else if (step) begin
      if (div_q) begin
        if (!diff[WIDTH]) begin
          hi_q <= diff[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_q <= shifted[WIDTH-1:0];
          lo_q <= {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_q, lo_q} <= {add_sum, lo_q[WIDTH-1:1]};
      end
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// Sequencer for the iterative mul/div unit beside EX; owns architectural HI/LO,
// raises stall for HI/LO users while busy and serves MFHI/MFLO/MTHI/MTLO.
module ex_muldiv_ctrl
  import ex_muldiv_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_rd,
  input  logic             hilo_wr,
  input  logic             hilo_sel,
  input  logic             flush,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hilo_rdata,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);

  // Handshake: start/hilo_rd/hilo_wr are requests from EX; the request is consumed at a
  // rising edge only in a cycle where stall=0 and flush=0. While stalled EX holds it unchanged.

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q, neg_res_q, neg_rem_q, div0_q, done_q;
  logic [WIDTH-1:0] hi_q, lo_q, core_hi, core_lo, mag_a, mag_b;
  logic             accept, soft_wr, core_step, sgn_a, sgn_b;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  always_comb begin
    sgn_a     = op_is_signed(op) & op_a[WIDTH-1];
    sgn_b     = op_is_signed(op) & op_b[WIDTH-1];
    mag_a     = sgn_a ? -op_a : op_a;
    mag_b     = sgn_b ? -op_b : op_b;
    accept    = (state_q == S_IDLE) & start & ~flush;
    soft_wr   = (state_q == S_IDLE) & hilo_wr & ~flush;
    core_step = (state_q == S_MUL) | (state_q == S_DIV);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (accept) state_d = op_is_div(op) ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (cnt_q == CW'(WIDTH-1)) state_d = S_FIX;
      S_FIX:        state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // Sign fix-up; a zero divisor forces an all-ones quotient whatever the operand signs.
  always_comb begin
    prod_fix = neg_res_q ? -{core_hi, core_lo} : {core_hi, core_lo};
    quo_fix  = div0_q ? '1 : (neg_res_q ? -core_lo : core_lo);
    rem_fix  = neg_rem_q ? -core_hi : core_hi;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= (state_q == S_FIX);
      if (accept) begin
        cnt_q     <= '0;
        is_div_q  <= op_is_div(op);
        neg_res_q <= sgn_a ^ sgn_b;
        neg_rem_q <= sgn_a;
        div0_q    <= op_is_div(op) & (op_b == '0);
      end else if (core_step) begin
        cnt_q <= (cnt_q == CW'(WIDTH-1)) ? '0 : cnt_q + CW'(1);
      end
      if (state_q == S_FIX) begin
        if (is_div_q) begin
          hi_q <= rem_fix;
          lo_q <= quo_fix;
        end else begin
          {hi_q, lo_q} <= prod_fix;
        end
      end else if (soft_wr) begin
        if (hilo_sel) hi_q <= op_a;
        else          lo_q <= op_a;
      end
    end
  end

  ex_muldiv_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (core_step),
    .mode_div (op_is_div(op)),
    .a        (mag_a),
    .b        (mag_b),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  assign busy       = (state_q != S_IDLE);
  assign stall      = busy & (start | hilo_rd | hilo_wr);
  assign done       = done_q;
  assign hilo_rdata = hilo_sel ? hi_q : lo_q;
  assign dbg_state  = state_q;

endmodule
